// File: rtl/aes_inv_key_sched_if.sv
// Round-key stream between the inverse AES-128 key scheduler and its consumer.
// The master side loads the key and accepts round keys; the slave is the scheduler.
interface aes_inv_key_sched_if;
  logic         load_key;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  modport master (
    output load_key, key_in, rk_ready,
    input  rk_valid, rk_out, rk_round, busy, done
  );

  modport slave (
    input  load_key, key_in, rk_ready,
    output rk_valid, rk_out, rk_round, busy, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: from the round-10 key, emits round keys 10 down to 0,
// one per handshake, using a shared external combinational S-box.
module aes_inv_key_sched #(
  parameter int unsigned NR = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_inv_key_sched_if.slave   ks,
  output logic [31:0]          sbox_in,
  input  logic [31:0]          sbox_out
);

  typedef enum logic [2:0] {StIdle, StOut, StSub, StExpand, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] kreg_q, kreg_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon;

  // Rcon of the key currently held; the key being recovered is one round earlier.
  always_comb begin
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    round_d = round_q;
    sbox_in = '0;
    case (state_q)
      StIdle: begin
        if (ks.load_key) begin
          kreg_d  = ks.key_in;
          round_d = 4'(NR);
          state_d = StOut;
        end
      end
      StOut: begin
        if (ks.rk_ready) state_d = (round_q == 4'd0) ? StDone : StSub;
      end
      StSub: begin
        // Undo the forward XOR chain for words 1..3; word 0 waits for the S-box.
        kreg_d  = {kreg_q[127:96], kreg_q[127:96] ^ kreg_q[95:64],
                   kreg_q[95:64] ^ kreg_q[63:32], kreg_q[63:32] ^ kreg_q[31:0]};
        state_d = StExpand;
      end
      StExpand: begin
        sbox_in              = {kreg_q[23:0], kreg_q[31:24]};
        kreg_d[127:96]       = kreg_q[127:96] ^ sbox_out ^ {rcon, 24'h0};
        round_d              = round_q - 4'd1;
        state_d              = StOut;
      end
      StDone: begin
        round_d = 4'(NR);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      kreg_q  <= '0;
      round_q <= 4'(NR);
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      round_q <= round_d;
    end
  end

  assign ks.rk_valid = (state_q == StOut);
  assign ks.rk_out   = kreg_q;
  assign ks.rk_round = round_q;
  assign ks.busy     = (state_q != StIdle);
  assign ks.done     = (state_q == StDone);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 vector, backpressure, ignored load, mid-run reset
// and random round trips against a forward-expansion model.
module tb_aes_inv_key_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;

  aes_inv_key_sched_if ks ();

  aes_inv_key_sched #(.NR(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .ks       (ks.slave),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_keys [11];
  logic [127:0] got_keys [11];

  assign sbox_out = {sbox_tab[sbox_in[31:24]], sbox_tab[sbox_in[23:16]],
                     sbox_tab[sbox_in[15:8]],  sbox_tab[sbox_in[7:0]]};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]};
  endfunction

  // Forward AES-128 expansion: exp_keys[r] is round key r.
  task automatic build_sched(input logic [127:0] key);
    logic [7:0]  rc;
    logic [31:0] w0, w1, w2, w3;
    logic [127:0] prev;
    rc = 8'h01;
    exp_keys[0] = key;
    for (int r = 1; r <= 10; r++) begin
      prev = exp_keys[r-1];
      w0 = prev[127:96] ^ sub_rot(prev[31:0]) ^ {rc, 24'h0};
      w1 = prev[95:64] ^ w0;
      w2 = prev[63:32] ^ w1;
      w3 = prev[31:0] ^ w2;
      exp_keys[r] = {w0, w1, w2, w3};
      rc = xtime(rc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 128'(ks.rk_valid), 128'd0);
    check({tag, "_busy"},  128'(ks.busy),     128'd0);
    check({tag, "_done"},  128'(ks.done),     128'd0);
    check({tag, "_sbox"},  128'(sbox_in),     128'd0);
    check({tag, "_round"}, 128'(ks.rk_round), 128'd10);
    check({tag, "_key"},   ks.rk_out,         128'd0);
  endtask

  // Loads exp_keys[10] and consumes the schedule. stall_round/load_round = 99 disables.
  task automatic run_schedule(input int stall_round, input int load_round);
    int   cyc;
    int   exp_round;
    int   stalls;
    logic ready;
    logic hold;
    @(negedge clk);
    check("idle_busy", 128'(ks.busy), 128'd0);
    ks.load_key = 1'b1;
    ks.key_in   = exp_keys[10];
    ks.rk_ready = 1'b1;
    @(negedge clk);
    ks.load_key = 1'b0;
    check("first_valid", 128'(ks.rk_valid), 128'd1);
    cyc = 2;
    exp_round = 10;
    stalls = 0;
    hold = 1'b0;
    while (!ks.done && cyc < 200) begin
      if (hold) check("hold_valid", 128'(ks.rk_valid), 128'd1);
      ready = 1'b1;
      if (ks.rk_valid) begin
        check("rk_round", 128'(ks.rk_round), 128'(exp_round));
        check("rk_out", ks.rk_out, exp_keys[exp_round]);
        got_keys[ks.rk_round] = ks.rk_out;
        if (exp_round == stall_round && stalls < 5) begin
          ready = 1'b0;
          stalls++;
        end
        if (ready) exp_round--;
      end
      hold = !ready;
      ks.rk_ready = ready;
      ks.load_key = (exp_round == load_round);
      ks.key_in   = ~exp_keys[10];
      @(negedge clk);
      cyc++;
    end
    ks.load_key = 1'b0;
    ks.rk_ready = 1'b1;
    check("done_seen", 128'(ks.done), 128'd1);
    check("done_busy", 128'(ks.busy), 128'd1);
    check("rounds_left", 128'(exp_round + 1), 128'd0);
    check("cycles", 128'(cyc), 128'(33 + stalls));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] key;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    reset = 1'b1;
    ks.load_key = 1'b0;
    ks.key_in   = '0;
    ks.rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // FIPS-197 A.1 vector
    build_sched(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_schedule(99, 99);
    check("fips_r10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_r9",  got_keys[9],  128'hac7766f319fadc2128d12941575c006e);
    check("fips_r0",  got_keys[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_schedule(7, 99);   // backpressure at round 7
    run_schedule(99, 4);   // load_key while busy

    // Reset in EXPAND at rk_round=3
    @(negedge clk);
    ks.load_key = 1'b1;
    ks.key_in   = exp_keys[10];
    @(negedge clk);
    ks.load_key = 1'b0;
    repeat (23) @(negedge clk);
    check("exp_round", 128'(ks.rk_round), 128'd3);
    check("exp_valid", 128'(ks.rk_valid), 128'd0);
    check("exp_sbox_in", 128'(sbox_in),
          128'({exp_keys[2][23:0], exp_keys[2][31:24]}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midrst");
    repeat (3) begin
      @(negedge clk);
      check("midrst_nodone", 128'(ks.done), 128'd0);
    end
    run_schedule(99, 99);

    // Random round trips, each started back-to-back after the previous done
    for (int k = 0; k < 20; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      build_sched(key);
      run_schedule(99, 99);
      check("rt_key0", got_keys[0], key);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
